// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction ROM with multi-lane sequential fetch into a FIFO feeding decode.
// Optional flush/redirect support is compiled in with `define FETCH_REDIRECT_EN.
module instr_fetch_queue #(
    parameter int ROM_WORDS   = 256,
    parameter int QUEUE_DEPTH = 8,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rom_wr_en,
    input  logic [$clog2(ROM_WORDS)-1:0] rom_wr_addr,
    input  logic [31:0]                  rom_wr_data,
    input  logic [$clog2(ROM_WORDS):0]   rom_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_pc,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         fetch_complete,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy
);
    localparam int AW = $clog2(ROM_WORDS);
    localparam int QW = $clog2(QUEUE_DEPTH);

    logic [31:0]   rom_mem   [ROM_WORDS];
    logic [31:0]   instr_mem [QUEUE_DEPTH];
    logic [31:0]   pc_mem    [QUEUE_DEPTH];

    logic [31:0]   pc_q, pc_d;
    logic [QW-1:0] head_q, head_d;
    logic [QW-1:0] tail_q, tail_d;
    logic [QW:0]   count_q, count_d;
    logic          fetch_done_q, fetch_done_d;

    logic          redirect;
    logic          deq;
    logic [31:0]   pc_word;
    logic [31:0]   free_slots;
    logic [31:0]   rem_words;
    logic [31:0]   enq_k;
    logic [31:0]   lane_instr [FETCH_WIDTH];
    logic [31:0]   lane_pc    [FETCH_WIDTH];
    logic [QW-1:0] lane_slot  [FETCH_WIDTH];

`ifdef FETCH_REDIRECT_EN
    logic unused_redirect_lsb;
    assign redirect            = redirect_valid;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`else
    logic unused_redirect;
    assign redirect        = 1'b0;
    assign unused_redirect = ^{redirect_valid, redirect_pc};
`endif

    // ROM is not reset; a same-cycle write is seen by fetch only from the next cycle
    always_ff @(posedge clk) begin
        if (rom_wr_en) begin
            rom_mem[rom_wr_addr] <= rom_wr_data;
        end
    end

    always_comb begin
        pc_word    = {2'b00, pc_q[31:2]};
        deq        = (count_q != '0) && out_ready;
        free_slots = 32'(QUEUE_DEPTH) - 32'(count_q) + 32'(deq);
        rem_words  = (pc_word < 32'(rom_len)) ? (32'(rom_len) - pc_word) : '0;

        enq_k = 32'(FETCH_WIDTH);
        if (free_slots < enq_k) enq_k = free_slots;
        if (rem_words < enq_k)  enq_k = rem_words;

        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            lane_instr[i] = rom_mem[AW'(pc_word + i)];
            lane_pc[i]    = pc_q + 32'(4 * i);
            lane_slot[i]  = tail_q + QW'(i);
        end

        head_d       = head_q + QW'(deq);
        tail_d       = tail_q + QW'(enq_k);
        count_d      = count_q + (QW+1)'(enq_k) - (QW+1)'(deq);
        pc_d         = pc_q + (enq_k << 2);
        fetch_done_d = ({2'b00, pc_d[31:2]} >= 32'(rom_len));

        // Redirect wins: drop everything left after this cycle's dequeue and skip enqueue
        if (redirect) begin
            enq_k        = '0;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            pc_d         = {redirect_pc[31:2], 2'b00};
            fetch_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            if (i < enq_k) begin
                instr_mem[lane_slot[i]] <= lane_instr[i];
                pc_mem[lane_slot[i]]    <= lane_pc[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fetch_done_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fetch_done_q <= fetch_done_d;
        end
    end

    assign out_valid      = (count_q != '0);
    assign out_instr      = out_valid ? instr_mem[head_q] : '0;
    assign out_pc         = out_valid ? pc_mem[head_q] : '0;
    assign occupancy      = count_q;
    assign fetch_complete = fetch_done_q && (count_q == '0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized self-checking bench for instr_fetch_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_fetch_queue;
    localparam int ROM_WORDS   = 256;
    localparam int QUEUE_DEPTH = 8;
    localparam int FETCH_WIDTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rom_wr_en = 1'b0;
    logic [7:0]  rom_wr_addr = '0;
    logic [31:0] rom_wr_data = '0;
    logic [8:0]  rom_len = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_complete;
    logic [3:0]  occupancy;

    instr_fetch_queue #(
        .ROM_WORDS  (ROM_WORDS),
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .FETCH_WIDTH(FETCH_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_wr_en     (rom_wr_en),
        .rom_wr_addr   (rom_wr_addr),
        .rom_wr_data   (rom_wr_data),
        .rom_len       (rom_len),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_complete(fetch_complete),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: program image, queue contents as (pc, instr) pairs, fetch PC, done flag
    logic [31:0] rom_m [ROM_WORDS];
    int unsigned mq_pc [$];
    logic [31:0] mq_instr [$];
    int unsigned m_pc = 0;
    bit          m_done = 0;

    logic        e_valid, e_cpl;
    logic [31:0] e_pc, e_instr;
    int unsigned e_occ;

    task automatic model_expect();
        e_valid = (mq_pc.size() > 0);
        e_pc    = e_valid ? mq_pc[0] : 32'd0;
        e_instr = e_valid ? mq_instr[0] : 32'd0;
        e_occ   = mq_pc.size();
        e_cpl   = m_done && (mq_pc.size() == 0);
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        int unsigned deq, free, rem, k, w;
        if (reset) begin
            mq_pc.delete(); mq_instr.delete(); m_pc = 0; m_done = 0;
        end
`ifdef FETCH_REDIRECT_EN
        else if (redirect_valid) begin
            mq_pc.delete(); mq_instr.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_done = 0;
        end
`endif
        else begin
            deq  = (mq_pc.size() > 0 && out_ready) ? 1 : 0;
            free = QUEUE_DEPTH - mq_pc.size() + deq;
            w    = m_pc / 4;
            rem  = (w < rom_len) ? rom_len - w : 0;
            k    = FETCH_WIDTH;
            if (free < k) k = free;
            if (rem < k)  k = rem;
            if (deq == 1) begin
                void'(mq_pc.pop_front());
                void'(mq_instr.pop_front());
            end
            for (int unsigned i = 0; i < k; i++) begin
                mq_pc.push_back(m_pc + 4 * i);
                mq_instr.push_back(rom_m[(w + i) % ROM_WORDS]);
            end
            m_pc   = m_pc + 4 * k;
            m_done = (m_pc / 4 >= rom_len);
        end
        if (rom_wr_en) rom_m[rom_wr_addr] = rom_wr_data;
        @(posedge clk);
        #1 rom_wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_prog(input int unsigned len, input logic [31:0] base, input logic [31:0] stride);
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
        for (int unsigned i = 0; i < len; i++) begin
            rom_wr_en = 1'b1; rom_wr_addr = 8'(i); rom_wr_data = base + stride * i;
            tick();
        end
        rom_len = 9'(len);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        n_cmp++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        n_cmp++; if (fetch_complete !== 1'b0) begin n_fail++; $display("FAIL reset_cpl: got %b want 0", fetch_complete); end
    endtask

    task automatic test_stream();
        load_prog(5, 32'h0050_0093, 32'h0010_0000);
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            model_expect();
            n_cmp++; if (out_valid !== e_valid) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid, e_valid); end
            n_cmp++; if (occupancy !== 4'(e_occ)) begin n_fail++; $display("FAIL stream_occ c%0d: got %0d want %0d", c, occupancy, e_occ); end
            n_cmp++; if (fetch_complete !== e_cpl) begin n_fail++; $display("FAIL stream_cpl c%0d: got %b want %b", c, fetch_complete, e_cpl); end
            if (e_valid) begin
                n_cmp++; if (out_pc !== e_pc) begin n_fail++; $display("FAIL stream_pc c%0d: got %h want %h", c, out_pc, e_pc); end
                n_cmp++; if (out_instr !== e_instr) begin n_fail++; $display("FAIL stream_instr c%0d: got %h want %h", c, out_instr, e_instr); end
            end
            if (c >= 1 && c <= 5) begin
                n_cmp++; if (out_pc !== 32'(4 * (c - 1))) begin n_fail++; $display("FAIL stream_seq c%0d: got %h want %h", c, out_pc, 4 * (c - 1)); end
            end
            if (c == 6) begin
                n_cmp++; if (fetch_complete !== 1'b1) begin n_fail++; $display("FAIL stream_done: got %b want 1", fetch_complete); end
            end
            tick();
        end
    endtask

    task automatic test_fill();
        load_prog(20, $urandom, $urandom | 32'd1);
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            model_expect();
            n_cmp++; if (occupancy !== 4'(e_occ)) begin n_fail++; $display("FAIL fill_occ c%0d: got %0d want %0d", c, occupancy, e_occ); end
            if (c >= 4) begin
                n_cmp++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_full c%0d: got %0d want 8", c, occupancy); end
                n_cmp++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL fill_head c%0d: got %h want 0", c, out_pc); end
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_deq_occ: got %0d want 8", occupancy); end
        n_cmp++; if (out_pc !== 32'd4) begin n_fail++; $display("FAIL fill_deq_pc: got %h want 4", out_pc); end
        for (int c = 0; c < 40; c++) begin
            out_ready = ($urandom % 3) != 0;
            model_expect();
            n_cmp++; if (occupancy !== 4'(e_occ)) begin n_fail++; $display("FAIL drain_occ c%0d: got %0d want %0d", c, occupancy, e_occ); end
            n_cmp++; if (fetch_complete !== e_cpl) begin n_fail++; $display("FAIL drain_cpl c%0d: got %b want %b", c, fetch_complete, e_cpl); end
            if (e_valid) begin
                n_cmp++; if (out_pc !== e_pc) begin n_fail++; $display("FAIL drain_pc c%0d: got %h want %h", c, out_pc, e_pc); end
                n_cmp++; if (out_instr !== e_instr) begin n_fail++; $display("FAIL drain_instr c%0d: got %h want %h", c, out_instr, e_instr); end
            end
            tick();
        end
    endtask

    task automatic test_short();
        load_prog(3, $urandom, 32'h0000_1111);
        out_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c >= 4) out_ready = $urandom % 2;
            model_expect();
            n_cmp++; if (occupancy !== 4'(e_occ)) begin n_fail++; $display("FAIL short_occ c%0d: got %0d want %0d", c, occupancy, e_occ); end
            n_cmp++; if (fetch_complete !== e_cpl) begin n_fail++; $display("FAIL short_cpl c%0d: got %b want %b", c, fetch_complete, e_cpl); end
            if (e_valid) begin
                n_cmp++; if (out_pc !== e_pc) begin n_fail++; $display("FAIL short_pc c%0d: got %h want %h", c, out_pc, e_pc); end
            end
            n_cmp++; if (out_valid && out_pc >= 32'd12) begin n_fail++; $display("FAIL short_bound c%0d: got %h want below 0000000c", c, out_pc); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_prog(5, $urandom, 32'h0000_0004);
        out_ready = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL rmid_pre_occ: got %0d want 5", occupancy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_valid: got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL rmid_async_occ: got %0d want 0", occupancy); end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            model_expect();
            n_cmp++; if (occupancy !== 4'(e_occ)) begin n_fail++; $display("FAIL rmid_occ c%0d: got %0d want %0d", c, occupancy, e_occ); end
            if (out_valid && !seen) begin
                seen = 1;
                n_cmp++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL rmid_first_pc: got %h want 0", out_pc); end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
`ifdef FETCH_REDIRECT_EN
        load_prog(20, $urandom, 32'h0000_0010);
        out_ready = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (occupancy !== 4'd6) begin n_fail++; $display("FAIL redir_pre_occ: got %0d want 6", occupancy); end
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2A;
        tick();
        redirect_valid = 1'b0;
        n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL redir_flush: got %0d want 0", occupancy); end
        tick();
        n_cmp++; if (out_pc !== 32'h28) begin n_fail++; $display("FAIL redir_pc: got %h want 00000028", out_pc); end
        n_cmp++; if (out_instr !== rom_m[10]) begin n_fail++; $display("FAIL redir_instr: got %h want %h", out_instr, rom_m[10]); end
`else
        load_prog(12, $urandom, 32'h0000_0010);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            redirect_valid = $urandom % 2; redirect_pc = $urandom;
            model_expect();
            n_cmp++; if (occupancy !== 4'(e_occ)) begin n_fail++; $display("FAIL noredir_occ c%0d: got %0d want %0d", c, occupancy, e_occ); end
            if (e_valid) begin
                n_cmp++; if (out_pc !== e_pc) begin n_fail++; $display("FAIL noredir_pc c%0d: got %h want %h", c, out_pc, e_pc); end
            end
            tick();
        end
        redirect_valid = 1'b0;
`endif
    endtask

    task automatic test_random();
        int unsigned len;
        for (int p = 0; p < 6; p++) begin
            len = (p == 0) ? 0 : $urandom_range(1, 40);
            load_prog(len, $urandom, $urandom | 32'd1);
            for (int c = 0; c < 45; c++) begin
                out_ready = ($urandom % 4) != 0;
                if (len > 0 && ($urandom % 5) == 0) begin
                    rom_wr_en = 1'b1;
                    rom_wr_addr = (($urandom % 2) == 0) ? 8'((m_pc / 4) % ROM_WORDS) : 8'($urandom_range(0, len - 1));
                    rom_wr_data = $urandom;
                end
`ifdef FETCH_REDIRECT_EN
                redirect_valid = ($urandom % 12) == 0;
                redirect_pc = $urandom_range(0, len * 4 + 8);
`endif
                model_expect();
                n_cmp++; if (out_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid p%0d c%0d: got %b want %b", p, c, out_valid, e_valid); end
                n_cmp++; if (occupancy !== 4'(e_occ)) begin n_fail++; $display("FAIL rnd_occ p%0d c%0d: got %0d want %0d", p, c, occupancy, e_occ); end
                n_cmp++; if (fetch_complete !== e_cpl) begin n_fail++; $display("FAIL rnd_cpl p%0d c%0d: got %b want %b", p, c, fetch_complete, e_cpl); end
                if (e_valid) begin
                    n_cmp++; if (out_pc !== e_pc) begin n_fail++; $display("FAIL rnd_pc p%0d c%0d: got %h want %h", p, c, out_pc, e_pc); end
                    n_cmp++; if (out_instr !== e_instr) begin n_fail++; $display("FAIL rnd_instr p%0d c%0d: got %h want %h", p, c, out_instr, e_instr); end
                end
                if (len == 0 && c == 1) begin
                    n_cmp++; if (fetch_complete !== 1'b1) begin n_fail++; $display("FAIL rnd_empty_prog: got %b want 1", fetch_complete); end
                end
                tick();
            end
            redirect_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_short();
        test_reset_mid();
        test_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter ROM_WORDS, default 256; instruction ROM depth in 32-bit words, power of 2.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 8; instruction queue entries, power of 2, at least 2*FETCH_WIDTH.
REQ-003 SHALL have parameter FETCH_WIDTH, default 2; instructions fetched per cycle, legal values 1 or 2.
REQ-004 SHALL have the following ports, clock and reset first; AW = log2(ROM_WORDS), QW = log2(QUEUE_DEPTH):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rom_wr_en  in  1  ROM write strobe
- rom_wr_addr  in  AW  ROM word address
- rom_wr_data  in  32  ROM write data, little-endian word already assembled
- rom_len  in  AW+1  program length in words; fetch stops at PC = rom_len*4
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  32  byte PC of head
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new byte PC
- fetch_complete  out  1  program exhausted and queue drained
- occupancy  out  QW+1  valid queue entries

Function
REQ-005 SHALL keep a 32-bit byte PC with bits [1:0] always 0; ROM is indexed by PC[AW+1:2].
REQ-006 SHALL read the ROM combinationally; an instruction fetched in cycle N SHALL appear at the head no earlier than cycle N+1 (1-cycle fetch-to-output latency into an empty queue).
REQ-007 Each cycle SHALL enqueue k = min(FETCH_WIDTH, free slots, remaining words) instructions at PC, PC+4, ... in program order and advance PC by 4*k; free slots include the entry dequeued in the same cycle.
REQ-008 SHALL never enqueue partially: if free slots < k, only whole lower-order lanes enqueue; no lane is skipped or reordered.
REQ-009 Dequeue SHALL occur on a cycle with out_valid && out_ready; out_instr/out_pc SHALL be stable while out_valid && !out_ready.
REQ-010 Simultaneous enqueue and dequeue SHALL update occupancy by k-1 in that cycle; occupancy SHALL never exceed QUEUE_DEPTH or go below 0.
REQ-011 Head/tail pointers SHALL wrap modulo QUEUE_DEPTH; full is occupancy == QUEUE_DEPTH, empty is occupancy == 0.
REQ-012 A PC word index >= rom_len SHALL stop fetch (fetch_done); fetch_complete = fetch_done && empty.
REQ-013 A ROM write to an address being fetched in the same cycle SHALL return the old data; the new data is visible from the next cycle.
REQ-014 rom_len == 0 SHALL give fetch_complete = 1 one cycle after reset release, with no enqueues.

Reset
REQ-015 On reset assertion, asynchronously: PC = 0, queue empty, occupancy = 0, out_valid = 0, out_instr = 0, out_pc = 0, fetch_done = 0, fetch_complete = 0; ROM contents SHALL be preserved.
REQ-016 Reset asserted mid-operation SHALL discard all queued entries; fetch SHALL restart at PC 0 on the first clock edge after release.

Configuration
REQ-017 With FETCH_REDIRECT_EN defined: redirect_valid SHALL, at the clock edge, flush all entries not dequeued in that cycle, set PC = {redirect_pc[31:2], 2'b00}, clear fetch_done, and suppress that cycle's enqueue; redirect_valid SHALL take priority over enqueue.
REQ-018 Without FETCH_REDIRECT_EN: redirect_valid and redirect_pc SHALL remain ports but be ignored; the PC advances only sequentially.

Verification
REQ-019 Load 5 words 0x00500093.., rom_len = 5, out_ready = 1, FETCH_WIDTH = 2 -> out_pc sequence 0,4,8,12,16 on consecutive cycles; fetch_complete = 1 the cycle after PC 16 dequeues.
REQ-020 out_ready = 0, rom_len = 20, QUEUE_DEPTH = 8 -> occupancy reaches 8 after 4 cycles and holds; PC = 32; head stays PC 0.
REQ-021 Full queue, assert out_ready for one cycle -> occupancy 8 -> 8 (one dequeue plus one enqueue at PC 32); next out_pc = 4.
REQ-022 FETCH_REDIRECT_EN, occupancy 6, redirect_pc = 0x2A, out_ready = 1 -> the dequeued head is consumed, occupancy 0 next cycle, then out_pc = 0x28.
REQ-023 Assert reset with occupancy 5 -> out_valid = 0 and occupancy = 0 immediately, before any clock edge; after release, first out_pc = 0.
REQ-024 rom_len = 3, FETCH_WIDTH = 2 -> second fetch cycle enqueues only PC 8; PC stops at 12; no word at PC 12 is ever output.
